// File: rtl/if_fetch_if.sv
// Fetch-stage bundle: shared 8-bit memory read port plus the decode-side
// valid/stall/redirect handshake. master = fetch stage, slave = its environment.
interface if_fetch_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  mem_busy;
  logic [7:0]            mem_din;
  logic [ADDR_WIDTH-1:0] mem_a;
  logic                  mem_rd;
  logic                  stall;
  logic                  br_taken;
  logic [31:0]           br_target;
  logic                  inst_valid;
  logic [31:0]           pc;
  logic [31:0]           inst;

  modport master (
    input  mem_busy, mem_din, stall, br_taken, br_target,
    output mem_a, mem_rd, inst_valid, pc, inst
  );

  modport slave (
    output mem_busy, mem_din, stall, br_taken, br_target,
    input  mem_a, mem_rd, inst_valid, pc, inst
  );
endinterface

// File: rtl/if_fetch.sv
// Instruction fetch: assembles 32-bit little-endian words from a byte-serial
// memory port and presents them to decode with a valid/stall handshake.
module if_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          ADDR_WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  if_fetch_if.master bus
);
  typedef enum logic {FETCH, HOLD} state_t;

  state_t      state_reg;
  logic [31:0] fetch_pc_reg;
  logic [31:0] inst_buf_reg;
  logic [2:0]  issue_idx_reg;
  logic [2:0]  recv_idx_reg;
  logic        pending_reg;
  logic        inst_valid_reg;
  logic [31:0] pc_reg;
  logic [31:0] inst_reg;

  logic [31:0] issue_addr;
  logic [31:0] assembled;
  logic [31:0] redirect_pc;
  logic [31:0] next_pc;
  logic        issue;
  logic        word_done;
  logic        out_free;

  // Gated by rst so the port stays quiet while reset is asserted.
  assign issue = rst && (state_reg == FETCH) && (issue_idx_reg < 3'd4) &&
                 !bus.mem_busy && !bus.br_taken;

  assign issue_addr  = fetch_pc_reg + {29'd0, issue_idx_reg};
  assign bus.mem_a   = issue_addr[ADDR_WIDTH-1:0];
  assign bus.mem_rd  = issue;

  assign redirect_pc = bus.br_target & ~32'h3;
  assign next_pc     = fetch_pc_reg + 32'd4;
  assign word_done   = pending_reg && (recv_idx_reg == 3'd3);
  assign out_free    = !inst_valid_reg || !bus.stall;

  // Buffer with the arriving byte merged into its lane.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_byte
      assign assembled[8*gi +: 8] = (pending_reg && recv_idx_reg == 3'(gi)) ?
                                    bus.mem_din : inst_buf_reg[8*gi +: 8];
    end
  endgenerate

  assign bus.inst_valid = inst_valid_reg;
  assign bus.pc         = pc_reg;
  assign bus.inst       = inst_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= FETCH;
      fetch_pc_reg   <= RESET_PC;
      inst_buf_reg   <= 32'd0;
      issue_idx_reg  <= 3'd0;
      recv_idx_reg   <= 3'd0;
      pending_reg    <= 1'b0;
      inst_valid_reg <= 1'b0;
      pc_reg         <= 32'd0;
      inst_reg       <= 32'd0;
    end else if (bus.br_taken) begin
      // Redirect discards any byte in flight and any held word.
      state_reg      <= FETCH;
      fetch_pc_reg   <= redirect_pc;
      inst_buf_reg   <= 32'd0;
      issue_idx_reg  <= 3'd0;
      recv_idx_reg   <= 3'd0;
      pending_reg    <= 1'b0;
      inst_valid_reg <= 1'b0;
    end else begin
      pending_reg <= issue;
      if (issue) begin
        issue_idx_reg <= issue_idx_reg + 3'd1;
      end
      case (state_reg)
        FETCH: begin
          if (word_done) begin
            if (out_free) begin
              inst_reg       <= assembled;
              pc_reg         <= fetch_pc_reg;
              inst_valid_reg <= 1'b1;
              fetch_pc_reg   <= next_pc;
              issue_idx_reg  <= 3'd0;
              recv_idx_reg   <= 3'd0;
            end else begin
              inst_buf_reg <= assembled;
              recv_idx_reg <= 3'd4;
              state_reg    <= HOLD;
            end
          end else begin
            if (pending_reg) begin
              inst_buf_reg <= assembled;
              recv_idx_reg <= recv_idx_reg + 3'd1;
            end
            if (inst_valid_reg && !bus.stall) begin
              inst_valid_reg <= 1'b0;
            end
          end
        end
        HOLD: begin
          if (!bus.stall) begin
            inst_reg       <= inst_buf_reg;
            pc_reg         <= fetch_pc_reg;
            inst_valid_reg <= 1'b1;
            fetch_pc_reg   <= next_pc;
            issue_idx_reg  <= 3'd0;
            recv_idx_reg   <= 3'd0;
            state_reg      <= FETCH;
          end
        end
        default: state_reg <= FETCH;
      endcase
    end
  end
endmodule
